// File: rtl/echo_arb_pkg.sv
// Shared definitions for the echo arbiter: payload width, tag depth and owner encoding.
package echo_arb_pkg;

  localparam int unsigned ECHO_WIDTH     = 704;
  localparam int unsigned TAG_DEPTH_DEF  = 4;
  localparam int unsigned CNT_W          = 16;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_e;

endpackage

// File: rtl/echo_arb_tag_fifo.sv
// Owner-tag FIFO: remembers which client issued each outstanding engine request.
module tag_fifo
  import echo_arb_pkg::*;
#(
  parameter int unsigned DEPTH = TAG_DEPTH_DEF
) (
  input  logic   CLK,
  input  logic   RST,
  input  logic   push,
  input  logic   pop,
  input  owner_e din,
  output logic   full,
  output logic   empty,
  output owner_e head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_FW = $clog2(DEPTH + 1);

  owner_e             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_FW-1:0]  count;
  logic               do_push;
  logic               do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CNT_FW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_FW'(1);
        2'b01:   count <= count - CNT_FW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/echo_arb.sv
// Two-client arbiter in front of a shared echo engine; routes echoes back in issue order.
module echo_arb
  import echo_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = ECHO_WIDTH,
  parameter int unsigned TAG_DEPTH = TAG_DEPTH_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              a_say__ENA,
  input  logic [WIDTH-1:0]  a_say_v,
  output logic              a_say__RDY,
  input  logic              b_say__ENA,
  input  logic [WIDTH-1:0]  b_say_v,
  output logic              b_say__RDY,
  output logic              a_heard__ENA,
  output logic [WIDTH-1:0]  a_heard_v,
  input  logic              a_heard__RDY,
  output logic              b_heard__ENA,
  output logic [WIDTH-1:0]  b_heard_v,
  input  logic              b_heard__RDY,
  output logic              dn_say__ENA,
  output logic [WIDTH-1:0]  dn_say_v,
  input  logic              dn_say__RDY,
  input  logic              up_heard__ENA,
  input  logic [WIDTH-1:0]  up_heard_v,
  output logic              up_heard__RDY,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b,
  output logic              err
);

  owner_e g;
  owner_e head;
  logic   full;
  logic   empty;
  logic   base_rdy;
  logic   push;
  logic   pop;
  logic   route_rdy;

  // Offer the engine slot to the client whose turn it is; everything is quiet in reset.
  assign base_rdy   = dn_say__RDY & ~full & ~RST;
  assign a_say__RDY = base_rdy & (g == OWNER_A);
  assign b_say__RDY = base_rdy & (g == OWNER_B);

  assign dn_say__ENA = (a_say__ENA | b_say__ENA) & ~RST;
  assign dn_say_v    = (g == OWNER_B) ? b_say_v : a_say_v;
  assign push        = base_rdy & ((g == OWNER_B) ? b_say__ENA : a_say__ENA);

  // Head-of-line owner gates the response; no bypass to the other client.
  assign route_rdy     = (head == OWNER_B) ? b_heard__RDY : a_heard__RDY;
  assign up_heard__RDY = ~empty & route_rdy & ~RST;
  assign a_heard__ENA  = up_heard__ENA & ~empty & (head == OWNER_A) & ~RST;
  assign b_heard__ENA  = up_heard__ENA & ~empty & (head == OWNER_B) & ~RST;
  assign a_heard_v     = up_heard_v;
  assign b_heard_v     = up_heard_v;
  assign pop           = up_heard__ENA & up_heard__RDY;

  tag_fifo #(
    .DEPTH(TAG_DEPTH)
  ) u_tag_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .pop   (pop),
    .din   (g),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      g     <= OWNER_A;
      cnt_a <= '0;
      cnt_b <= '0;
      err   <= 1'b0;
    end else begin
      if (base_rdy) g <= (g == OWNER_A) ? OWNER_B : OWNER_A;
      if (pop) begin
        if (head == OWNER_B) cnt_b <= cnt_b + CNT_W'(1);
        else                 cnt_a <= cnt_a + CNT_W'(1);
      end
      // A response with nothing outstanding is a protocol violation; keep it visible.
      if (up_heard__ENA & empty) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_echo_arb.sv
// Randomized bench for echo_arb against a queue-based model, plus directed scenario pins.
module tb_echo_arb;
  import echo_arb_pkg::*;

  localparam int unsigned W = ECHO_WIDTH;
  localparam int unsigned D = TAG_DEPTH_DEF;

  logic          clk;
  logic          rst;
  logic          a_say_ena, b_say_ena, a_say_rdy, b_say_rdy;
  logic [W-1:0]  a_say_v, b_say_v;
  logic          a_heard_ena, b_heard_ena, a_heard_rdy, b_heard_rdy;
  logic [W-1:0]  a_heard_v, b_heard_v;
  logic          dn_ena, dn_rdy, up_ena, up_rdy;
  logic [W-1:0]  dn_v, up_v;
  logic [15:0]   cnt_a, cnt_b;
  logic          err;

  echo_arb dut (
    .CLK           (clk),
    .RST           (rst),
    .a_say__ENA    (a_say_ena),
    .a_say_v       (a_say_v),
    .a_say__RDY    (a_say_rdy),
    .b_say__ENA    (b_say_ena),
    .b_say_v       (b_say_v),
    .b_say__RDY    (b_say_rdy),
    .a_heard__ENA  (a_heard_ena),
    .a_heard_v     (a_heard_v),
    .a_heard__RDY  (a_heard_rdy),
    .b_heard__ENA  (b_heard_ena),
    .b_heard_v     (b_heard_v),
    .b_heard__RDY  (b_heard_rdy),
    .dn_say__ENA   (dn_ena),
    .dn_say_v      (dn_v),
    .dn_say__RDY   (dn_rdy),
    .up_heard__ENA (up_ena),
    .up_heard_v    (up_v),
    .up_heard__RDY (up_rdy),
    .cnt_a         (cnt_a),
    .cnt_b         (cnt_b),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: owner tags in flight, engine echo queue, per-client expected echoes.
  bit            g_m;
  bit            tags_m[$];
  logic [W-1:0]  eng_q[$];
  logic [W-1:0]  sa_q[$];
  logic [W-1:0]  sb_q[$];
  int unsigned   ca_m, cb_m;
  bit            err_m;

  int total;
  int bad;

  logic          seen_a_rdy, seen_b_rdy, seen_up_rdy, seen_dn_ena, seen_err;
  logic [15:0]   seen_cnt_a, seen_cnt_b;
  logic [W-1:0]  seen_dn_v, drv_a, drv_b;

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int i = 0; i < int'(W / 32); i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    chk(name, W'(act), W'(exp));
  endtask

  // One clock: drive at negedge, compare combinational and registered outputs, advance model.
  task automatic step(input bit r, input bit dn, input bit ahr, input bit bhr,
                      input bit aw, input bit bw, input bit uw, input bit inj);
    bit base, ar, br, ur, ae, be, ue, ow, hd, pop;
    int n;
    @(negedge clk);
    n    = tags_m.size();
    hd   = (n > 0) ? tags_m[0] : 1'b0;
    base = !r && dn && (n < int'(D));
    ar   = base && !g_m;
    br   = base && g_m;
    ur   = !r && (n > 0) && (hd ? bhr : ahr);
    ae   = aw && ar;
    be   = bw && br;
    ue   = (uw && ur) || (inj && !r && n == 0);
    drv_a = rand_vec();
    drv_b = rand_vec();
    rst         = r;
    dn_rdy      = dn;
    a_heard_rdy = ahr;
    b_heard_rdy = bhr;
    a_say_ena   = ae;
    b_say_ena   = be;
    a_say_v     = drv_a;
    b_say_v     = drv_b;
    up_ena      = ue;
    up_v        = (eng_q.size() > 0) ? eng_q[0] : rand_vec();
    #1;
    seen_a_rdy  = a_say_rdy;
    seen_b_rdy  = b_say_rdy;
    seen_up_rdy = up_rdy;
    seen_dn_ena = dn_ena;
    seen_dn_v   = dn_v;
    seen_err    = err;
    seen_cnt_a  = cnt_a;
    seen_cnt_b  = cnt_b;

    chkb("a_say_rdy", a_say_rdy, ar);
    chkb("b_say_rdy", b_say_rdy, br);
    chkb("dn_ena", dn_ena, ae || be);
    if (ae || be) chk("dn_v", dn_v, g_m ? drv_b : drv_a);
    chkb("up_rdy", up_rdy, ur);
    chkb("a_heard_ena", a_heard_ena, ue && !r && n > 0 && !hd);
    chkb("b_heard_ena", b_heard_ena, ue && !r && n > 0 && hd);
    if (ue && n > 0 && !hd && sa_q.size() > 0) chk("a_heard_v", a_heard_v, sa_q[0]);
    if (ue && n > 0 && hd && sb_q.size() > 0)  chk("b_heard_v", b_heard_v, sb_q[0]);
    chk("cnt_a", W'(cnt_a), W'(ca_m));
    chk("cnt_b", W'(cnt_b), W'(cb_m));
    chkb("err", err, err_m);

    if (r) begin
      g_m = 1'b0;
      tags_m.delete();
      eng_q.delete();
      sa_q.delete();
      sb_q.delete();
      ca_m  = 0;
      cb_m  = 0;
      err_m = 1'b0;
    end else begin
      pop = ue && ur;
      if (ue && n == 0) err_m = 1'b1;
      if (pop) begin
        ow = tags_m.pop_front();
        void'(eng_q.pop_front());
        if (ow) begin
          cb_m = (cb_m + 1) % 65536;
          if (sb_q.size() > 0) void'(sb_q.pop_front());
        end else begin
          ca_m = (ca_m + 1) % 65536;
          if (sa_q.size() > 0) void'(sa_q.pop_front());
        end
      end
      if (ae || be) begin
        tags_m.push_back(g_m);
        eng_q.push_back(g_m ? drv_b : drv_a);
        if (g_m) sb_q.push_back(drv_b);
        else     sa_q.push_back(drv_a);
      end
      if (base) g_m = !g_m;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; dn_rdy = 1'b0; a_heard_rdy = 1'b0; b_heard_rdy = 1'b0;
    a_say_ena = 1'b0; b_say_ena = 1'b0; up_ena = 1'b0;
    a_say_v = '0; b_say_v = '0; up_v = '0;

    // Both clients always fire: issue alternates A,B,A,B; two echoes each.
    step(1, 1, 1, 1, 0, 0, 0, 0);
    chkb("rst_a_rdy", seen_a_rdy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 1, 1, 1, 0, 0);
      chk("alt_dn_v", seen_dn_v, (i % 2 == 0) ? drv_a : drv_b);
    end
    for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 0, 0, 1, 0);
    step(0, 1, 1, 1, 0, 0, 0, 0);
    chk("alt_cnt_a", W'(seen_cnt_a), W'(16'd2));
    chk("alt_cnt_b", W'(seen_cnt_b), W'(16'd2));

    // Only A active: offered every other cycle, three echoes in order.
    step(1, 1, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 1, 1, 1, 0, 0, 0);
      chkb("a_only_rdy", seen_a_rdy, (i % 2 == 0));
    end
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0, 0, 1, 0);
    step(0, 1, 1, 1, 0, 0, 0, 0);
    chk("a_only_cnt_a", W'(seen_cnt_a), W'(16'd3));
    chk("a_only_cnt_b", W'(seen_cnt_b), W'(16'd0));

    // Full with head blocked; one pop reopens the slot on the following cycle.
    step(1, 1, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 1, 1, 1, 0);
    chkb("full_a_rdy", seen_a_rdy, 1'b0);
    chkb("full_b_rdy", seen_b_rdy, 1'b0);
    chkb("full_up_rdy", seen_up_rdy, 1'b0);
    step(0, 1, 1, 0, 0, 0, 1, 0);
    chkb("full_pop_a_rdy", seen_a_rdy, 1'b0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chkb("reopen_a_rdy", seen_a_rdy, 1'b1);

    // Head owned by B: A being ready must not let the response through.
    step(1, 1, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 1, 0, 0);
    step(0, 1, 1, 1, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0, 0, 1, 0);
    chkb("hol_blocked", seen_up_rdy, 1'b0);
    step(0, 1, 0, 1, 0, 0, 1, 0);
    chkb("hol_release", seen_up_rdy, 1'b1);
    step(0, 1, 1, 1, 0, 0, 0, 0);
    chk("hol_cnt_b", W'(seen_cnt_b), W'(16'd1));

    // Response while empty: sticky error, counters untouched, cleared by reset only.
    step(1, 1, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 0, 1);
    step(0, 1, 1, 1, 0, 0, 0, 0);
    chkb("err_set", seen_err, 1'b1);
    chk("err_cnt_a", W'(seen_cnt_a), W'(16'd0));
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 1, 1, 1, 0);
    chkb("err_sticky", seen_err, 1'b1);
    step(1, 1, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 0, 0);
    chkb("err_cleared", seen_err, 1'b0);

    // Reset with three outstanding discards them.
    step(1, 1, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, 1, 0, 0);
    step(1, 1, 1, 1, 1, 1, 1, 0);
    chkb("midrst_a_rdy", seen_a_rdy, 1'b0);
    chkb("midrst_dn_ena", seen_dn_ena, 1'b0);
    chkb("midrst_up_rdy", seen_up_rdy, 1'b0);
    step(0, 1, 1, 1, 0, 0, 1, 0);
    chkb("post_rst_a_rdy", seen_a_rdy, 1'b1);
    chkb("post_rst_up_rdy", seen_up_rdy, 1'b0);
    chk("post_rst_cnt_a", W'(seen_cnt_a), W'(16'd0));

    // Random traffic against the model.
    step(1, 1, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 300) == 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
           ($urandom % 3) != 0, ($urandom % 3) != 0, ($urandom % 3) != 0,
           ($urandom % 2) == 0, ($urandom % 40) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/echo_arb.md
ECHO_ARB -- requirements
Module: echo_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 704, payload width of every say/heard vector.
REQ-002 SHALL have parameter TAG_DEPTH, default 4, number of outstanding requests tracked (power of two).
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports a$say__ENA in 1, a$say$v in WIDTH, a$say__RDY out 1: client A request method.
REQ-006 SHALL have ports b$say__ENA in 1, b$say$v in WIDTH, b$say__RDY out 1: client B request method.
REQ-007 SHALL have ports a$heard__ENA out 1, a$heard$v out WIDTH, a$heard__RDY in 1: client A indication.
REQ-008 SHALL have ports b$heard__ENA out 1, b$heard$v out WIDTH, b$heard__RDY in 1: client B indication.
REQ-009 SHALL have ports dn$say__ENA out 1, dn$say$v out WIDTH, dn$say__RDY in 1: shared echo engine request.
REQ-010 SHALL have ports up$heard__ENA in 1, up$heard$v in WIDTH, up$heard__RDY out 1: shared echo engine indication.
REQ-011 SHALL have ports cnt_a out 16, cnt_b out 16 (completed echoes per client), err out 1 (sticky protocol error).

Function
REQ-012 SHALL obey ENA/RDY method rules: no RDY output depends combinationally on any ENA input; a method fires when its ENA is high (ENA high only while RDY high).
REQ-013 SHALL hold a 1-bit grant register g (0=A, 1=B); base_rdy = dn$say__RDY & (tag count < TAG_DEPTH).
REQ-014 SHALL drive a$say__RDY = base_rdy & ~g and b$say__RDY = base_rdy & g.
REQ-015 SHALL toggle g on every cycle where base_rdy is high, whether or not the offered client fires; hold g otherwise.
REQ-016 SHALL drive dn$say__ENA = a$say__ENA | b$say__ENA and dn$say$v = selected client payload, zero latency.
REQ-017 SHALL push the owner bit (g) into the tag FIFO on each dn$say fire.
REQ-018 SHALL drive up$heard__RDY = tag nonempty & (head==0 ? a$heard__RDY : b$heard__RDY).
REQ-019 SHALL drive a$heard__ENA = up$heard__ENA & head==0, b$heard__ENA = up$heard__ENA & head==1; a$heard$v and b$heard$v both equal up$heard$v.
REQ-020 SHALL pop the tag FIFO and increment cnt_a or cnt_b (wrap 0xFFFF->0) on each up$heard fire.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and preserve order; pointers wrap modulo TAG_DEPTH.
REQ-022 Full: base_rdy low, neither client offered, g holds; pop while full reopens base_rdy next cycle.
REQ-023 Empty: up$heard__RDY low; up$heard__ENA observed while empty SHALL set err (sticky), no pop, no counter change.
REQ-024 Responses SHALL be routed strictly in issue order.

Reset
REQ-025 On RST high at a clock edge: g=0, tag FIFO empty (pointers 0, count 0), cnt_a=cnt_b=0, err=0.
REQ-026 Reset mid-operation SHALL discard all outstanding tags; the shared engine is reset by the same RST.
REQ-027 During reset cycle all __RDY and __ENA outputs SHALL be 0.

Structure
REQ-028 WIDTH default, TAG_DEPTH default, and owner encoding (OWNER_A=0, OWNER_B=1) SHALL live in the shared echo package.
REQ-029 SHALL instantiate one sub-module tag_fifo (1-bit wide, TAG_DEPTH deep, push/pop/full/empty/head, same CLK/RST).
REQ-030 Arbitration, routing and counters SHALL reside in echo_arb itself.

Verification
REQ-031 Reset, dn$say__RDY=1, both clients always fire -> dn$say$v alternates A,B,A,B; after 4 issues and 4 heard with both heard__RDY=1: cnt_a=2, cnt_b=2.
REQ-032 Only A active, engine ready -> A offered every other cycle; 3 sends complete with cnt_a=3, cnt_b=0, a$heard$v equals sent values in order.
REQ-033 Hold up$heard__RDY path blocked (a$heard__RDY=0) with 4 outstanding -> both say__RDY=0 until one pop; next cycle base_rdy=1.
REQ-034 Head owner B, b$heard__RDY=0, a$heard__RDY=1 -> up$heard__RDY=0 (no bypass); releases when b$heard__RDY=1.
REQ-035 Inject up$heard__ENA with tag FIFO empty -> err=1 and stays 1; counters 0; cleared only by RST.
REQ-036 Assert RST with 3 outstanding -> next cycle count=0, g=0, cnt_a=cnt_b=0, a$say__RDY=1 when dn$say__RDY=1.
